conv_stream: RTL and testbench
==============================

# conv_stream

Parametrised 1-D valid-mode convolution engine for the stream datapath. It accepts an N-sample signed vector x and an M-tap signed filter f over independent valid/ready slave ports, and emits N-M+1 outputs on a valid/ready master port. It supersedes the fixed 8x4 convolver with:
- configurable widths, lengths and multiplier parallelism;
- an optional ReLU output stage;
- explicit reuse of a loaded filter across vectors.

## Interface
- T, 8: signed input sample/tap width.
- N, 8: x vector length; N >= M.
- M, 4: filter length; M % P == 0.
- P, 4: multipliers per cycle; 1 <= P <= M.
- RELU, 0: 1 clamps negative outputs to 0.
- YW, 2*T+$clog2(M): output width, derived; must not be overridden.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- s_data_in_x  in  T  x sample, signed.
- s_valid_x / s_ready_x  in/out  1  x handshake.
- s_data_in_f  in  T  filter tap, signed.
- s_valid_f / s_ready_f  in/out  1  f handshake.
- keep_f  in  1  sampled at the last output handshake; 1 retains the loaded filter for the next vector.
- m_data_out_y  out  YW  result, signed.
- m_valid_y / m_ready_y  out/in  1  y handshake.

## Operation
- Storage: an x buffer of N entries and an f buffer of M entries. Write counters cnt_x (0..N) and cnt_f (0..M).
- A transfer occurs on any edge where valid and ready are both high.
- s_ready_x = (state==LOAD) && cnt_x<N && reset; s_ready_f = (state==LOAD) && cnt_f<M && reset. Both are combinational.
- x and f load independently and in any interleaving. The i-th x transfer writes x[i]; the j-th f transfer writes f[j].
- States:
  - LOAD: accepts x and f. Goes to COMPUTE on the edge where cnt_x==N and cnt_f==M both hold, counting a transfer on that same edge.
  - COMPUTE: for output k, issues M/P read beats. Beat b reads x[k+bP .. k+bP+P-1] and f[bP .. bP+P-1]. The P products are summed and added to the accumulator. The accumulator is cleared at the start of each k.
  - OUT: m_valid_y=1 and m_data_out_y holds y[k] stable until the handshake.
    - On handshake with k<N-M: k++ and return to COMPUTE.
    - On handshake with k==N-M: cnt_x=0; cnt_f=0 unless keep_f==1; go to LOAD.
- Arithmetic: y[k] = sum over j=0..M-1 of x[k+j]*f[j]. Products are full 2T-bit signed. Accumulation is YW-bit signed and cannot overflow.
- RELU=1: y = (acc<0) ? 0 : acc.
- Data presented while valid is low is X and must never be consumed.

## Timing
- Reset values: s_ready_x=0 and s_ready_f=0 while reset is low; state=LOAD; k=0; cnt_x=0; cnt_f=0; m_valid_y=0; m_data_out_y=0.
- After reset is released, both s_ready signals are high in the first full cycle.
- Buffer reads have 1-cycle latency.
- m_valid_y rises M/P+1 cycles after the edge that completed loading.
- After each y handshake, the next m_valid_y rises M/P+1 cycles later.
- With m_ready_y tied high, one vector takes (N-M+1)*(M/P+2) cycles after loading.
- m_valid_y never falls without a handshake. m_data_out_y is stable while m_valid_y=1 and m_ready_y=0.
- Full buffer: the s_ready for that input drops on the edge where it fills. The other input keeps loading.
- No input is accepted outside LOAD. Data offered early stalls upstream.
- keep_f=1 at the final handshake: on the next cycle s_ready_f=0 and s_ready_x=1. COMPUTE starts when cnt_x reaches N.
- Reset asserted mid-operation: all state clears asynchronously. Any partial load, accumulator or pending output is discarded, with no spurious m_valid_y.
- After the last output, m_valid_y stays 0 until a full new load completes.

## Test plan
- Defaults, x={10,-20,30,-40,50,60,70,80}, f={10,20,-30,40}, random valid/ready gaps:
  - required y = {-2800,3600,400,1600,2800}, in order, with no extras in the following 100 cycles.
- Defaults, second vector x={-90,100,-110,120,-50,40,30,-20}, f={-50,-60,70,80}:
  - required y = {400,6000,-2000,2200,600}. Also check that f loads fully before any x arrives.
- P=1 and P=2, x={1..8}, f={1,1,1,1}, m_ready_y tied high:
  - required y = {10,14,18,22,26}.
  - First m_valid_y exactly M/P+1 cycles after the last load edge.
- keep_f=1 after f={1,1,1,1}, then x={11,22,33,44,55,66,77,88} with no f sent:
  - required y = {110,154,198,242,286}; s_ready_f stays 0 throughout.
- RELU=1 with the first scenario's data:
  - required y = {0,3600,400,1600,2800}.
- Backpressure and reset:
  - Hold m_ready_y=0 for 20 cycles: y stays stable and valid stays high.
  - Assert reset mid-COMPUTE: m_valid_y=0 immediately and both s_ready signals are 0 while reset is low.
  - After release, a full reload gives correct results.

Source files
------------

// File: rtl/conv_stream.sv
// rtl/conv_stream.sv - streaming 1-D valid-mode convolution engine
//
// Loads an N-sample signed vector x and an M-tap signed filter f over two
// independent valid/ready slave ports, then emits the N-M+1 valid-mode
// outputs y[k] = sum_j x[k+j]*f[j] on a valid/ready master port.
// P products are formed per cycle; RELU=1 clamps negative outputs to zero.
//
// Ports:
//   clk                       rising-edge clock
//   reset                     asynchronous active-low reset
//   s_data_in_x/s_valid_x/s_ready_x   x sample stream (signed, T bits)
//   s_data_in_f/s_valid_f/s_ready_f   filter tap stream (signed, T bits)
//   keep_f                    sampled on the final y handshake; 1 keeps the filter
//   m_data_out_y/m_valid_y/m_ready_y  result stream (signed, YW bits)
module conv_stream #(
  parameter int T    = 8,
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int P    = 4,
  parameter int RELU = 0,
  parameter int YW   = 2*T + $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [T-1:0]  s_data_in_x,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  input  logic [T-1:0]  s_data_in_f,
  input  logic          s_valid_f,
  output logic          s_ready_f,
  input  logic          keep_f,
  output logic [YW-1:0] m_data_out_y,
  output logic          m_valid_y,
  input  logic          m_ready_y
);

  localparam int BEATS = M / P;
  localparam int XA    = (N > 1) ? $clog2(N) : 1;
  localparam int FA    = (M > 1) ? $clog2(M) : 1;
  localparam int CXW   = $clog2(N + 1);
  localparam int CFW   = $clog2(M + 1);
  localparam int BW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

  state_t                state_q;
  logic [T-1:0]          x_q [N];
  logic [T-1:0]          f_q [M];
  logic [CXW-1:0]        cnt_x_q, cnt_x_d;
  logic [CFW-1:0]        cnt_f_q, cnt_f_d;
  logic [XA-1:0]         k_q;
  logic [BW-1:0]         b_q;
  logic signed [T-1:0]   rdx_q [P];
  logic signed [T-1:0]   rdf_q [P];
  logic signed [YW-1:0]  acc_q;
  logic [YW-1:0]         y_q;
  logic                  valid_q;

  logic                  xfer_x, xfer_f, load_done;
  logic [XA-1:0]         xa [P];
  logic [FA-1:0]         fa [P];
  logic signed [2*T-1:0] prod;
  logic signed [YW-1:0]  psum, total, y_d;

  assign s_ready_x    = (state_q == LOAD) && (cnt_x_q < CXW'(N)) && reset;
  assign s_ready_f    = (state_q == LOAD) && (cnt_f_q < CFW'(M)) && reset;
  assign m_valid_y    = valid_q;
  assign m_data_out_y = y_q;

  assign xfer_x    = s_valid_x && s_ready_x;
  assign xfer_f    = s_valid_f && s_ready_f;
  assign cnt_x_d   = cnt_x_q + CXW'(xfer_x);
  assign cnt_f_d   = cnt_f_q + CFW'(xfer_f);
  // Loading completes on the edge that makes both buffers full, including
  // a transfer landing on that same edge.
  assign load_done = (cnt_x_d == CXW'(N)) && (cnt_f_d == CFW'(M));

  always_comb begin
    psum = '0;
    prod = '0;
    for (int i = 0; i < P; i++) begin
      xa[i] = XA'(int'(k_q) + int'(b_q) * P + i);
      fa[i] = FA'(int'(b_q) * P + i);
      prod  = (2*T)'(rdx_q[i]) * (2*T)'(rdf_q[i]);
      psum  = psum + YW'(prod);
    end
    // rdx/rdf hold the beat read on the previous cycle; beat 0 lands when
    // b_q==1, which is where the accumulator restarts for this output.
    total = ((b_q == BW'(1)) ? '0 : acc_q) + psum;
    y_d   = ((RELU != 0) && total[YW-1]) ? '0 : total;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_x_q <= '0;
      cnt_f_q <= '0;
      k_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      for (int i = 0; i < M; i++) f_q[i] <= '0;
      for (int i = 0; i < P; i++) begin
        rdx_q[i] <= '0;
        rdf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer_x) x_q[cnt_x_q[XA-1:0]] <= s_data_in_x;
          if (xfer_f) f_q[cnt_f_q[FA-1:0]] <= s_data_in_f;
          cnt_x_q <= cnt_x_d;
          cnt_f_q <= cnt_f_d;
          if (load_done) begin
            state_q <= COMPUTE;
            k_q     <= '0;
            b_q     <= '0;
          end
        end
        COMPUTE: begin
          if (b_q < BW'(BEATS)) begin
            for (int i = 0; i < P; i++) begin
              rdx_q[i] <= x_q[xa[i]];
              rdf_q[i] <= f_q[fa[i]];
            end
          end
          if (b_q != '0) acc_q <= total;
          if (b_q == BW'(BEATS)) begin
            y_q     <= y_d;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            b_q <= b_q + BW'(1);
          end
        end
        OUT: begin
          if (m_ready_y) begin
            valid_q <= 1'b0;
            b_q     <= '0;
            if (k_q == XA'(N - M)) begin
              cnt_x_q <= '0;
              if (!keep_f) cnt_f_q <= '0;
              k_q     <= '0;
              state_q <= LOAD;
            end else begin
              k_q     <= k_q + XA'(1);
              state_q <= COMPUTE;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream.sv
// tb/tb_conv_stream.sv - self-checking bench for conv_stream
module tb_conv_stream;

  localparam int T  = 8;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int YW = 2*T + $clog2(M);

  logic          clk = 1'b0;
  logic          reset;
  logic [T-1:0]  x_data, f_data;
  logic [3:0]    vx, vf, rx, rf, mr, mv;
  logic          keep_f;
  logic [YW-1:0] y [4];

  always #5 clk = ~clk;

  // d0: P=4, d1: P=1, d2: P=2, d3: P=4 with ReLU
  conv_stream #(.P(4), .RELU(0)) u_d0 (
    .clk(clk), .reset(reset),
    .s_data_in_x(x_data), .s_valid_x(vx[0]), .s_ready_x(rx[0]),
    .s_data_in_f(f_data), .s_valid_f(vf[0]), .s_ready_f(rf[0]),
    .keep_f(keep_f),
    .m_data_out_y(y[0]), .m_valid_y(mv[0]), .m_ready_y(mr[0]));
  conv_stream #(.P(1), .RELU(0)) u_d1 (
    .clk(clk), .reset(reset),
    .s_data_in_x(x_data), .s_valid_x(vx[1]), .s_ready_x(rx[1]),
    .s_data_in_f(f_data), .s_valid_f(vf[1]), .s_ready_f(rf[1]),
    .keep_f(keep_f),
    .m_data_out_y(y[1]), .m_valid_y(mv[1]), .m_ready_y(mr[1]));
  conv_stream #(.P(2), .RELU(0)) u_d2 (
    .clk(clk), .reset(reset),
    .s_data_in_x(x_data), .s_valid_x(vx[2]), .s_ready_x(rx[2]),
    .s_data_in_f(f_data), .s_valid_f(vf[2]), .s_ready_f(rf[2]),
    .keep_f(keep_f),
    .m_data_out_y(y[2]), .m_valid_y(mv[2]), .m_ready_y(mr[2]));
  conv_stream #(.P(4), .RELU(1)) u_d3 (
    .clk(clk), .reset(reset),
    .s_data_in_x(x_data), .s_valid_x(vx[3]), .s_ready_x(rx[3]),
    .s_data_in_f(f_data), .s_valid_f(vf[3]), .s_ready_f(rf[3]),
    .keep_f(keep_f),
    .m_data_out_y(y[3]), .m_valid_y(mv[3]), .m_ready_y(mr[3]));

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q [$];
  bit rf_seen;

  int xa1 [8] = '{10, -20, 30, -40, 50, 60, 70, 80};
  int fa1 [4] = '{10, 20, -30, 40};
  int xa2 [8] = '{-90, 100, -110, 120, -50, 40, 30, -20};
  int fa2 [4] = '{-50, -60, 70, 80};
  int xr  [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int xk  [8] = '{11, 22, 33, 44, 55, 66, 77, 88};
  int ones[4] = '{1, 1, 1, 1};

  task automatic check(input string tag, input int obs, input int expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Offers x and f with random gaps; pushes the model's outputs when asked.
  task automatic load_vec(input int d, input int xs[8], input int fs[4],
                          input bit send_f, input bit f_first,
                          input bit relu, input bit push);
    int ix, jf, cyc, s;
    bit ox, of, hx, hf, chk_done;
    ix = 0; jf = send_f ? 0 : 4; cyc = 0; chk_done = 0; rf_seen = 0;
    while ((ix < 8 || jf < 4) && cyc < 1000) begin
      @(negedge clk);
      if (!send_f && rf[d]) rf_seen = 1;
      if (f_first && jf == 4 && ix == 0 && !chk_done) begin
        check("ffirst_ready_f_low", int'(rf[d]), 0);
        check("ffirst_ready_x_high", int'(rx[d]), 1);
        chk_done = 1;
      end
      ox = (ix < 8) && (!f_first || jf == 4) && ($urandom_range(0, 3) != 0);
      of = (jf < 4) && ($urandom_range(0, 3) != 0);
      x_data = T'($urandom);
      f_data = T'($urandom);
      if (ox) x_data = T'(xs[ix]);
      if (of) f_data = T'(fs[jf]);
      vx[d] = ox;
      vf[d] = of;
      hx = ox && rx[d];
      hf = of && rf[d];
      @(posedge clk);
      #1;
      if (hx) ix++;
      if (hf) jf++;
      cyc++;
    end
    vx[d] = 1'b0;
    vf[d] = 1'b0;
    check("load_complete", int'(ix == 8 && jf == 4), 1);
    if (push) begin
      for (int k = 0; k <= N - M; k++) begin
        s = 0;
        for (int j = 0; j < M; j++) s += xs[k+j] * fs[j];
        if (relu && s < 0) s = 0;
        exp_q.push_back(s);
      end
    end
  endtask

  // mode 0: random ready, 1: ready tied high, 2: 20-cycle stall on first y
  task automatic drain(input int d, input int n, input int mode);
    int got, cyc, e, held;
    bit bp_done;
    got = 0; cyc = 0; bp_done = 0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      if (mode == 1) mr[d] = 1'b1;
      else if (mode == 2 && !bp_done) mr[d] = 1'b0;
      else mr[d] = ($urandom_range(0, 2) != 0);
      #1;
      if (mode == 2 && !bp_done && mv[d]) begin
        held = $signed(y[d]);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          #1;
          check("bp_valid_high", int'(mv[d]), 1);
          check("bp_y_stable", $signed(y[d]), held);
        end
        bp_done = 1;
      end
      if (mv[d] && mr[d]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_y", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("y_d%0d_k%0d", d, got), $signed(y[d]), e);
        end
        got++;
      end
      cyc++;
    end
    check("drain_count", got, n);
    @(posedge clk);
    #1;
    mr[d] = 1'b0;
  endtask

  task automatic quiet(input int d);
    int extra;
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      mr[d] = 1'b1;
      #1;
      if (mv[d]) extra++;
    end
    mr[d] = 1'b0;
    check("no_extra_y", extra, 0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic first_valid(input int d, input int expc, input string tag);
    int c;
    c = 0;
    while (!mv[d] && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, c, expc);
  endtask

  initial begin
    reset = 1'b0; vx = '0; vf = '0; mr = '0; keep_f = 1'b0;
    x_data = '0; f_data = '0;
    #1;
    check("rst_ready_x", int'(rx[0]), 0);
    check("rst_ready_f", int'(rf[0]), 0);
    check("rst_valid", int'(mv[0]), 0);
    check("rst_y", $signed(y[0]), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready_x", int'(rx[0]), 1);
    check("post_rst_ready_f", int'(rf[0]), 1);

    // vector 1, random gaps
    load_vec(0, xa1, fa1, 1, 0, 0, 1);
    drain(0, 5, 0);
    quiet(0);

    // vector 2, f before x, output stall
    load_vec(0, xa2, fa2, 1, 1, 0, 1);
    drain(0, 5, 2);
    quiet(0);

    // P=1 and P=2 with ready tied high
    mr[1] = 1'b1;
    load_vec(1, xr, ones, 1, 0, 0, 1);
    first_valid(1, 5, "latency_p1");
    drain(1, 5, 1);
    quiet(1);
    mr[2] = 1'b1;
    load_vec(2, xr, ones, 1, 0, 0, 1);
    first_valid(2, 3, "latency_p2");
    drain(2, 5, 1);
    quiet(2);

    // filter reuse
    load_vec(0, xr, ones, 1, 0, 0, 1);
    keep_f = 1'b1;
    drain(0, 5, 0);
    keep_f = 1'b0;
    load_vec(0, xk, ones, 0, 0, 0, 1);
    check("keep_f_ready_f_low", int'(rf_seen), 0);
    drain(0, 5, 0);
    quiet(0);

    // ReLU
    load_vec(3, xa1, fa1, 1, 0, 1, 1);
    drain(3, 5, 0);
    quiet(3);

    // reset in the middle of COMPUTE on the P=1 engine
    load_vec(1, xa1, fa1, 1, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", int'(mv[1]), 0);
    check("midrst_y", $signed(y[1]), 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_ready_x", int'(rx[1]), 0);
      check("midrst_ready_f", int'(rf[1]), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    quiet(1);
    load_vec(1, xa1, fa1, 1, 0, 0, 1);
    drain(1, 5, 0);
    quiet(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
